// File: rtl/arb_pkg.sv
// Shared types and sizes for the 4-way round-robin mux arbiter.
package arb_pkg;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   // One-hot encoding of a requester index.
   function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority picker: first requester at or after ptr, wrapping mod 4.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [2*N_REQ-1:0] req_dbl;
   logic [2*N_REQ-1:0] req_sh;
   logic [N_REQ-1:0]   req_rot;
   logic [IDX_W-1:0]   offset;

   // Rotate so ptr lands on bit 0, then take the lowest set bit.
   always_comb begin
      req_dbl = {req, req};
      req_sh  = req_dbl >> ptr;
      req_rot = req_sh[N_REQ-1:0];
      found   = |req_rot;
      offset  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) offset = IDX_W'(k);
      end
      idx = ptr + offset;
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select pair and one-hot grant of a
// shared 4:1 mux resource, with an optional per-owner hold limit.
module mux_rr_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             sel1,
   output logic             sel0,
   output logic             busy,
   output logic             timeout
);

   localparam int HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam bit HOLD_LIMITED = (MAX_HOLD != 0);

   arb_state_t       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] sel_r;
   logic [HC_W-1:0]  hold_cnt;
   logic [N_REQ-1:0] gnt_r;
   logic             busy_r;
   logic             timeout_r;

   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;

   rr_pick4 u_pick (
      .req   (req),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // FSM with all outputs registered; sel keeps the last owner while idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         owner     <= '0;
         sel_r     <= '0;
         hold_cnt  <= '0;
         gnt_r     <= '0;
         busy_r    <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               timeout_r <= 1'b0;
               if (pick_found) begin
                  state    <= GRANT;
                  owner    <= pick_idx;
                  sel_r    <= pick_idx;
                  gnt_r    <= idx_onehot(pick_idx);
                  busy_r   <= 1'b1;
                  hold_cnt <= '0;
               end
            end
            GRANT: begin
               if (!req[owner] || (HOLD_LIMITED && hold_cnt == HOLD_LAST)) begin
                  // A voluntary release on the limit edge is not a timeout.
                  state     <= IDLE;
                  gnt_r     <= '0;
                  busy_r    <= 1'b0;
                  ptr       <= owner + IDX_W'(1);
                  timeout_r <= req[owner];
               end else begin
                  timeout_r <= 1'b0;
                  if (hold_cnt != '1) hold_cnt <= hold_cnt + HC_W'(1);
               end
            end
            default: begin
               state  <= IDLE;
               gnt_r  <= '0;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign gnt     = gnt_r;
   assign sel1    = sel_r[1];
   assign sel0    = sel_r[0];
   assign busy    = busy_r;
   assign timeout = timeout_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus a random
// phase, all cross-checked against a cycle-level reference model.
module tb_mux_rr_arbiter;

   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic       sel1, sel0, busy, timeout;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   // Expected {gnt, sel1, sel0, busy, timeout} after each edge.
   logic [7:0] exp_q[$];

   // Reference model state.
   int   m_ptr = 0, m_owner = 0, m_hold = 0, m_sel = 0;
   logic [3:0] m_gnt = 4'b0;
   bit   m_busy = 0, m_to = 0;

   mux_rr_arbiter #(.MAX_HOLD(MH)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .gnt     (gnt),
      .sel1    (sel1),
      .sel0    (sel0),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus at the falling edge, advance the model,
   // queue the expectation, and return at the next falling edge.
   task automatic drive(input logic [3:0] r, input bit rs);
      bit found;
      int cand;
      req    = r;
      reset  = rs;
      mon_en = 1'b1;
      if (rs) begin
         m_ptr = 0; m_owner = 0; m_hold = 0; m_sel = 0;
         m_gnt = 4'b0; m_busy = 0; m_to = 0;
      end else if (!m_busy) begin
         m_to  = 0;
         found = 0;
         for (int k = 0; k < 4; k++) begin
            cand = (m_ptr + k) % 4;
            if (!found && r[cand]) begin
               found   = 1;
               m_owner = cand;
            end
         end
         if (found) begin
            m_gnt  = 4'b0001 << m_owner;
            m_sel  = m_owner;
            m_busy = 1;
            m_hold = 0;
         end
      end else if (!r[m_owner] || (MH != 0 && m_hold == MH - 1)) begin
         m_to   = r[m_owner];
         m_gnt  = 4'b0;
         m_busy = 0;
         m_ptr  = (m_owner + 1) % 4;
      end else begin
         m_to   = 0;
         m_hold = m_hold + 1;
      end
      exp_q.push_back({m_gnt, 2'(m_sel), m_busy, m_to});
      @(negedge clk);
   endtask

   // Scoreboard and invariant monitor, sampling just after each rising edge.
   initial begin
      logic [7:0] e;
      logic [1:0] s;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            s = {sel1, sel0};
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               if ({gnt, sel1, sel0, busy, timeout} !== e) begin
                  errors++;
                  $display("FAIL scoreboard t=%0t: got gnt=%b sel=%b busy=%b to=%b, want gnt=%b sel=%b busy=%b to=%b",
                           $time, gnt, s, busy, timeout, e[7:4], e[3:2], e[1], e[0]);
               end
            end
            checks++;
            if (!$onehot0(gnt) || ((gnt != 4'b0) !== busy) || (gnt[s] !== busy)) begin
               errors++;
               $display("FAIL invariant t=%0t: gnt=%b sel=%b busy=%b", $time, gnt, s, busy);
            end
         end
      end
   end

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(4'b1111, 1'b1);
         checks++;
         if ({gnt, sel1, sel0, busy, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset_hold: got gnt=%b sel=%b%b busy=%b, want all zero", gnt, sel1, sel0, busy);
         end
      end
      drive(4'b1111, 1'b0);
      checks++;
      if (gnt !== 4'b0001 || {sel1, sel0} !== 2'b00 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_grant: got gnt=%b busy=%b, want gnt=0001 busy=1", gnt, busy);
      end
      drive(4'b0000, 1'b0);
      drive(4'b0000, 1'b0);
   endtask

   task automatic test_single_request();
      for (int i = 0; i < 3; i++) begin
         drive(4'b0100, 1'b0);
         checks++;
         if (gnt !== 4'b0100 || {sel1, sel0} !== 2'b10) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b sel=%b%b, want gnt=0100 sel=10", gnt, sel1, sel0);
         end
      end
      drive(4'b0000, 1'b0);
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || {sel1, sel0} !== 2'b10) begin
         errors++;
         $display("FAIL single_release: got gnt=%b busy=%b sel=%b%b, want gnt=0000 busy=0 sel=10",
                  gnt, busy, sel1, sel0);
      end
      // ptr is now 3, so requester 3 beats requester 0.
      drive(4'b1001, 1'b0);
      checks++;
      if (gnt !== 4'b1000) begin
         errors++;
         $display("FAIL ptr_after_release: got gnt=%b, want 1000", gnt);
      end
      drive(4'b0000, 1'b0);
      drive(4'b0000, 1'b0);
   endtask

   task automatic test_rotation_timeout();
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < MH; c++) begin
            drive(4'b1111, 1'b0);
            checks++;
            if (gnt !== (4'b0001 << (g % 4)) || timeout !== 1'b0) begin
               errors++;
               $display("FAIL rotate_hold g=%0d c=%0d: got gnt=%b to=%b, want gnt=%b to=0",
                        g, c, gnt, timeout, 4'b0001 << (g % 4));
            end
         end
         drive(4'b1111, 1'b0);
         checks++;
         if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL rotate_timeout g=%0d: got gnt=%b to=%b, want gnt=0000 to=1", g, gnt, timeout);
         end
      end
      drive(4'b0000, 1'b0);
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse_width: got to=%b, want 0", timeout);
      end
   endtask

   task automatic test_wrap();
      drive(4'b1000, 1'b0);
      checks++;
      if (gnt !== 4'b1000) begin
         errors++;
         $display("FAIL wrap_grant3: got gnt=%b, want 1000", gnt);
      end
      drive(4'b0001, 1'b0);
      checks++;
      if (gnt !== 4'b0000 || {sel1, sel0} !== 2'b11) begin
         errors++;
         $display("FAIL wrap_idle: got gnt=%b sel=%b%b, want gnt=0000 sel=11", gnt, sel1, sel0);
      end
      drive(4'b0001, 1'b0);
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_grant0: got gnt=%b, want 0001", gnt);
      end
      drive(4'b0000, 1'b0);
   endtask

   task automatic test_release_on_limit();
      for (int c = 0; c < MH; c++) drive(4'b0010, 1'b0);
      drive(4'b0000, 1'b0);
      checks++;
      if (gnt !== 4'b0000 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL release_on_limit: got gnt=%b to=%b, want gnt=0000 to=0", gnt, timeout);
      end
      drive(4'b0000, 1'b0);
   endtask

   task automatic test_reset_mid_grant();
      drive(4'b0100, 1'b0);
      drive(4'b0100, 1'b0);
      checks++;
      if (gnt !== 4'b0100) begin
         errors++;
         $display("FAIL midgrant_setup: got gnt=%b, want 0100", gnt);
      end
      drive(4'b0100, 1'b1);
      checks++;
      if (gnt !== 4'b0000 || {sel1, sel0} !== 2'b00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midgrant_reset: got gnt=%b sel=%b%b busy=%b, want 0000/00/0", gnt, sel1, sel0, busy);
      end
      drive(4'b0101, 1'b0);
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("FAIL midgrant_regrant: got gnt=%b, want 0001", gnt);
      end
      drive(4'b0000, 1'b0);
   endtask

   task automatic test_random();
      logic [3:0] r;
      for (int i = 0; i < 400; i++) begin
         r = 4'($urandom_range(0, 15));
         drive(r, ($urandom_range(0, 59) == 0));
      end
      drive(4'b0000, 1'b0);
      drive(4'b0000, 1'b0);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_request();
      test_rotation_timeout();
      test_wrap();
      test_release_on_limit();
      test_reset_mid_grant();
      test_random();
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
